uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
//  Front-end stage of the UART receiver, directly upstream of the RX control FSM.
//  Synchronises RX_IN, runs the oversampling edge/bit counters and takes a 3-sample
//  majority vote per bit. Feeds the FSM and checkers: rx_sync, edge_count, bit_count,
//  sampled_bit and a one-cycle sample_valid strobe.
// PARAMETERS
//  PRESCALE_W  5   width of prescale and edge_count
//  BIT_CNT_W   4   width of bit_count
// PORTS
//  clk             in   1           receiver oversampling clock
//  rst             in   1           synchronous reset, active-high
//  RX_IN           in   1           asynchronous serial line, idle high
//  Prescale        in   PRESCALE_W  oversampling ratio; legal values: even, 4..30
//  counter_enable  in   1           from FSM; counters run while high
//  data_sample_en  in   1           from FSM; majority sampling enabled while high
//  rx_sync         out  1           RX_IN after 2-FF synchroniser
//  edge_count      out  PRESCALE_W  oversample edge index within the current bit
//  bit_count       out  BIT_CNT_W   index of the current bit (start bit = 0)
//  sampled_bit     out  1           majority-voted value of the last sampled bit
//  sample_valid    out  1           1-cycle pulse: sampled_bit updated this cycle
//  sample_noisy    out  1           1-cycle pulse with sample_valid: 3 samples not unanimous
// BEHAVIOUR
//  Clock and reset: one clock (clk); rst is synchronous and active-high.
//  Reset values:
//   - sync FFs, rx_sync, sampled_bit = 1
//   - edge_count, bit_count, sample_valid, sample_noisy = 0
//   - all internal sample registers = 1
//  Synchroniser:
//   - rx_sync = RX_IN delayed 2 clk; no other filtering.
//   - All sampling uses rx_sync, never RX_IN.
//  Prescale:
//   - Prescale[0] is ignored (P = Prescale & ~1); half = P>>1.
//   - P < 4 is treated as P = 4.
//   - Prescale is sampled every cycle; changing it mid-frame is unsupported.
//  Edge counter:
//   - counter_enable=0: edge_count and bit_count load 0 on the next clk.
//     This has priority over every other counter action.
//   - counter_enable=1 and edge_count != P-1: edge_count+1.
//   - counter_enable=1 and edge_count == P-1: edge_count -> 0 and bit_count+1.
//  Bit counter:
//   - Saturates at 2^BIT_CNT_W-1 (15); it never wraps.
//   - A normal frame uses 0..10 (start, 8 data, parity, stop).
//  Sampling (only while data_sample_en=1 and counter_enable=1):
//   - Capture rx_sync at edge_count = half-1, half and half+1 into s0, s1, s2.
//   - The cycle after the capture at half+1: sampled_bit = maj(s0,s1,s2),
//     sample_valid=1, sample_noisy = !(s0==s1==s2).
//   - Latency: one vote per bit, available 1 clk after edge half+1, i.e. at edge half+2.
//     This matches the FSM decision point edge_count == half+2.
//  data_sample_en=0:
//   - No captures; sampled_bit holds; sample_valid and sample_noisy stay 0.
//   - Counters still follow counter_enable.
//  Corner cases:
//   - data_sample_en drops between captures: the partial s0..s2 are discarded;
//     no sample_valid pulse that bit.
//   - counter_enable drops in the same cycle as an edge wrap: clear wins,
//     bit_count -> 0 (not +1).
//   - rst mid-frame: all state returns to reset values on the next clk;
//     no sample_valid pulse is emitted.
//  Structure: no FSM in this block; it is counters plus a capture/vote pipeline.
// STRUCTURE
//  - Package uart_rx_pkg:
//    - PRESCALE_W, BIT_CNT_W
//    - UART_IDLE_LEVEL = 1'b1
//    - FRAME_BITS_PAR = 11, FRAME_BITS_NOPAR = 10
//    - function half_prescale()
//  - Sub-module uart_sync_2ff: generic 2-FF synchroniser with reset value 1.
//  - All other logic stays inline in uart_rx_sampler.
// TESTING
//  1. rst=1 for 3 clk with RX_IN=0 -> rx_sync=1, sampled_bit=1, counts=0,
//     sample_valid=0. RX_IN is asynchronous, so the synchroniser must not pass it
//     through during reset.
//  2. Prescale=8, counter_enable held 1 for 24 clk -> edge_count cycles 0..7;
//     bit_count reaches 1 at clk 8, 2 at clk 16, 3 at clk 24.
//  3. Prescale=8, data_sample_en=1, rx_sync low at edges 3,4,5 -> sample_valid
//     pulses at edge 6 with sampled_bit=0, sample_noisy=0.
//  4. Prescale=16, glitch makes only edge 7 high (edges 8,9 low) -> sampled_bit=0,
//     sample_noisy=1. Single-edge glitch at edge 8 -> same result.
//  5. Counter_enable drops while edge_count=P-1, bit_count=4 -> next clk:
//     edge_count=0, bit_count=0, no sample_valid.
//  6. Prescale=7 behaves exactly as 8; Prescale=2 behaves as 4 (half=2, votes at
//     edges 1,2,3). Run 20 bits -> bit_count saturates at 15.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_rx_pkg;

  localparam int PRESCALE_W = 5;
  localparam int BIT_CNT_W  = 4;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  localparam int FRAME_BITS_PAR   = 11;
  localparam int FRAME_BITS_NOPAR = 10;

  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(4);

  // Half of the effective oversampling ratio: odd values round down, tiny values clamp to 4.
  function automatic logic [PRESCALE_W-1:0] half_prescale(input logic [PRESCALE_W-1:0] prescale);
    logic [PRESCALE_W-1:0] p;
    p = prescale & ~PRESCALE_W'(1);
    if (p < MIN_PRESCALE) begin
      p = MIN_PRESCALE;
    end
    return p >> 1;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-stage synchroniser for an asynchronous single-bit input; resets to RESET_VALUE.
module uart_sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {2{RESET_VALUE}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: line synchroniser, oversampling edge/bit counters and
// a three-sample majority vote centred on each bit.
module uart_rx_sampler #(
  parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
  parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  counter_enable,
  input  logic                  data_sample_en,
  output logic                  rx_sync,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  sample_noisy
);

  import uart_rx_pkg::*;

  logic [PRESCALE_W-1:0] edge_count_reg;
  logic [BIT_CNT_W-1:0]  bit_count_reg;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  sampling;

  logic       s0_reg;
  logic       s1_reg;
  logic [1:0] cap_reg;
  logic       sampled_bit_reg;
  logic       sample_valid_reg;
  logic       sample_noisy_reg;

  uart_sync_2ff #(
    .RESET_VALUE(UART_IDLE_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (RX_IN),
    .q  (rx_sync)
  );

  assign half      = half_prescale(Prescale);
  assign last_edge = {half[PRESCALE_W-2:0], 1'b0} - PRESCALE_W'(1);
  assign sampling  = counter_enable & data_sample_en;

  // Dropping counter_enable clears both counters, even on a wrap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_count_reg <= '0;
      bit_count_reg  <= '0;
    end else if (!counter_enable) begin
      edge_count_reg <= '0;
      bit_count_reg  <= '0;
    end else if (edge_count_reg == last_edge) begin
      edge_count_reg <= '0;
      if (bit_count_reg != {BIT_CNT_W{1'b1}}) begin
        bit_count_reg <= bit_count_reg + BIT_CNT_W'(1);
      end
    end else begin
      edge_count_reg <= edge_count_reg + PRESCALE_W'(1);
    end
  end

  // cap_reg tracks how many of the three centre samples were taken back-to-back;
  // the third sample feeds the vote directly so the result lands at edge half+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_reg           <= UART_IDLE_LEVEL;
      s1_reg           <= UART_IDLE_LEVEL;
      cap_reg          <= 2'd0;
      sampled_bit_reg  <= UART_IDLE_LEVEL;
      sample_valid_reg <= 1'b0;
      sample_noisy_reg <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      sample_noisy_reg <= 1'b0;
      if (!sampling) begin
        s0_reg  <= UART_IDLE_LEVEL;
        s1_reg  <= UART_IDLE_LEVEL;
        cap_reg <= 2'd0;
      end else if (edge_count_reg == half - PRESCALE_W'(1)) begin
        s0_reg  <= rx_sync;
        cap_reg <= 2'd1;
      end else if (edge_count_reg == half && cap_reg == 2'd1) begin
        s1_reg  <= rx_sync;
        cap_reg <= 2'd2;
      end else if (edge_count_reg == half + PRESCALE_W'(1) && cap_reg == 2'd2) begin
        cap_reg          <= 2'd0;
        sampled_bit_reg  <= majority3(s0_reg, s1_reg, rx_sync);
        sample_valid_reg <= 1'b1;
        sample_noisy_reg <= !((s0_reg == s1_reg) && (s1_reg == rx_sync));
      end else begin
        cap_reg <= 2'd0;
      end
    end
  end

  assign edge_count   = edge_count_reg;
  assign bit_count    = bit_count_reg;
  assign sampled_bit  = sampled_bit_reg;
  assign sample_valid = sample_valid_reg;
  assign sample_noisy = sample_noisy_reg;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed scenarios plus random frames
// compared against an arithmetic model of the line, counters and majority vote.
module tb_uart_rx_sampler;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [4:0] prescale;
  logic       ce;
  logic       dse;
  logic       rx_sync;
  logic [4:0] edge_count;
  logic [3:0] bit_count;
  logic       sampled_bit;
  logic       sample_valid;
  logic       sample_noisy;

  int   n_checks;
  int   n_errors;
  logic exp_sampled;

  // lvl[k]: required rx_sync level in cycle k of a run; dse_arr[k]: data_sample_en in cycle k
  logic lvl     [0:1023];
  logic dse_arr [0:1023];

  uart_rx_sampler dut (
    .clk           (clk),
    .rst           (rst),
    .RX_IN         (rx_in),
    .Prescale      (prescale),
    .counter_enable(ce),
    .data_sample_en(dse),
    .rx_sync       (rx_sync),
    .edge_count    (edge_count),
    .bit_count     (bit_count),
    .sampled_bit   (sampled_bit),
    .sample_valid  (sample_valid),
    .sample_noisy  (sample_noisy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_p(input int presc);
    int p;
    p = presc & ~1;
    if (p < 4) p = 4;
    return p;
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < 1024; k++) begin
      lvl[k]     = 1'b1;
      dse_arr[k] = 1'b0;
    end
  endtask

  task automatic fill_random(input int presc, input int nbits, input bit drops);
    int   p;
    logic level;
    p = eff_p(presc);
    clear_frame();
    for (int b = 0; b < nbits; b++) begin
      level = 1'($urandom_range(0, 1));
      for (int e = 0; e < p; e++) begin
        lvl[b*p+e]     = level ^ ($urandom_range(0, 3) == 0);
        dse_arr[b*p+e] = drops ? ($urandom_range(0, 15) != 0) : 1'b1;
      end
    end
    lvl[0] = 1'b1;
    lvl[1] = 1'b1;
  endtask

  // Runs ncyc enabled cycles, then ends with either counter_enable low or a reset.
  task automatic run_cycles(input int presc, input int ncyc, input bit end_rst);
    int   p;
    int   half;
    int   base;
    int   ones;
    logic exp_valid;
    logic exp_noisy;
    p    = eff_p(presc);
    half = p / 2;
    prescale = 5'(presc);
    for (int k = 0; k <= ncyc; k++) begin
      exp_valid = 1'b0;
      exp_noisy = 1'b0;
      base = k - 3;
      if (k >= 3 && (base % p) == half - 1 &&
          dse_arr[base] && dse_arr[base+1] && dse_arr[base+2]) begin
        ones        = int'(lvl[base]) + int'(lvl[base+1]) + int'(lvl[base+2]);
        exp_valid   = 1'b1;
        exp_sampled = (ones >= 2);
        exp_noisy   = (ones == 1 || ones == 2);
      end
      $display("P=%0d k=%0d edge=%0d bit=%0d rx_sync=%0b valid=%0b bit_val=%0b noisy=%0b",
               p, k, edge_count, bit_count, rx_sync, sample_valid, sampled_bit, sample_noisy);
      chk("rx_sync", 32'(rx_sync), 32'(lvl[k]));
      chk("edge_count", 32'(edge_count), 32'(k % p));
      chk("bit_count", 32'(bit_count), 32'((k / p) > 15 ? 15 : (k / p)));
      chk("sample_valid", 32'(sample_valid), 32'(exp_valid));
      chk("sample_noisy", 32'(sample_noisy), 32'(exp_noisy));
      chk("sampled_bit", 32'(sampled_bit), 32'(exp_sampled));
      if (k < ncyc) begin
        ce    = 1'b1;
        dse   = dse_arr[k];
        rx_in = lvl[k+2];
      end else begin
        ce    = end_rst;
        dse   = end_rst ? dse_arr[k] : 1'b0;
        rst   = end_rst;
        rx_in = lvl[k+2];
      end
      @(posedge clk);
      #1;
    end
    rst   = 1'b0;
    ce    = 1'b0;
    dse   = 1'b0;
    rx_in = 1'b1;
    if (end_rst) exp_sampled = 1'b1;
    chk("end_edge_count", 32'(edge_count), 32'd0);
    chk("end_bit_count", 32'(bit_count), 32'd0);
    chk("end_sample_valid", 32'(sample_valid), 32'd0);
    chk("end_sample_noisy", 32'(sample_noisy), 32'd0);
    chk("end_sampled_bit", 32'(sampled_bit), 32'(exp_sampled));
    chk("end_rx_sync", 32'(rx_sync), end_rst ? 32'd1 : 32'(lvl[ncyc+1]));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int pr;
    int p;
    int nb;
    n_checks    = 0;
    n_errors    = 0;
    exp_sampled = 1'b1;
    rst      = 1'b1;
    rx_in    = 1'b0;
    ce       = 1'b0;
    dse      = 1'b0;
    prescale = 5'd8;

    // Reset with the line held low: nothing may leak through the synchroniser.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_sync", 32'(rx_sync), 32'd1);
    chk("rst_sampled_bit", 32'(sampled_bit), 32'd1);
    chk("rst_edge_count", 32'(edge_count), 32'd0);
    chk("rst_bit_count", 32'(bit_count), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample_noisy", 32'(sample_noisy), 32'd0);
    rst   = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_rx_sync", 32'(rx_sync), 32'd1);

    // Counters only, Prescale 8, 24 cycles
    clear_frame();
    run_cycles(8, 24, 1'b0);

    // Clean low bit at edges 3..5
    clear_frame();
    for (int k = 0; k < 8; k++) dse_arr[k] = 1'b1;
    for (int k = 3; k <= 5; k++) lvl[k] = 1'b0;
    run_cycles(8, 8, 1'b0);

    // Prescale 16 glitches: only edge 7 high, then only edge 8 high
    clear_frame();
    for (int k = 0; k < 32; k++) dse_arr[k] = 1'b1;
    lvl[7]  = 1'b1; lvl[8]  = 1'b0; lvl[9]  = 1'b0;
    lvl[23] = 1'b0; lvl[24] = 1'b1; lvl[25] = 1'b0;
    run_cycles(16, 32, 1'b0);

    // counter_enable drops at edge P-1 of bit 4
    fill_random(8, 5, 1'b0);
    run_cycles(8, 39, 1'b0);

    // Reset right after the third capture: no vote may appear
    clear_frame();
    for (int k = 0; k < 8; k++) dse_arr[k] = 1'b1;
    for (int k = 3; k <= 5; k++) lvl[k] = 1'b0;
    run_cycles(8, 5, 1'b1);

    // Odd and undersized Prescale, 20 bits to saturate bit_count
    fill_random(7, 20, 1'b1);
    run_cycles(7, 160, 1'b0);
    fill_random(2, 20, 1'b1);
    run_cycles(2, 80, 1'b0);

    // Random sweep over legal and odd Prescale values
    for (int i = 0; i < 6; i++) begin
      pr = 4 + 2 * int'($urandom_range(0, 13)) + int'($urandom_range(0, 1));
      p  = eff_p(pr);
      nb = int'($urandom_range(2, 12));
      fill_random(pr, nb, 1'b1);
      run_cycles(pr, nb * p + int'($urandom_range(0, p - 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
